// File: rtl/cosine_pkg.sv
// Shared constants, coefficient table and FSM states for the cosine series unit.
// Q5.11 fixed point throughout.
package cosine_pkg;

    localparam int FRAC_BITS = 11;
    localparam int WIDTH     = 16;
    localparam int ONE       = 2048;
    localparam int X_MAX     = 6434;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR,
        S_MULX,
        S_MULC,
        S_ACC,
        S_DONE
    } state_e;

    // 1/(2k(2k-1)) factors turning t_{k-1}*x^2 into the next Taylor term
    function automatic logic [WIDTH-1:0] coef(input logic [2:0] k);
        logic [WIDTH-1:0] c;
        c = '0;
        unique case (k)
            3'd1:    c = 16'd1024;
            3'd2:    c = 16'd171;
            3'd3:    c = 16'd68;
            3'd4:    c = 16'd37;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cosine_series_mult.sv
// Combinational Q5.11 unsigned multiply: product bits [26:11], truncated.
// Bits above 26 are dropped by the 16-bit cast.
module cosine_series_mult
    import cosine_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);

    assign p_o = WIDTH'((32'(a_i) * 32'(b_i)) >> FRAC_BITS);

endmodule

// File: rtl/cosine_series.sv
// Iterative Taylor-series cosine with one time-shared multiplier.
// Each term costs MULX, MULC and ACC cycles after a single squaring cycle.
module cosine_series
    import cosine_pkg::*;
#(
    parameter int N_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        range_err
);

    localparam logic [2:0]       K_LAST = 3'(N_TERMS);
    localparam logic [WIDTH-1:0] XMAXV  = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0] ONEV   = WIDTH'(ONE);

    state_e state_q, state_d;

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       k_q, k_d;
    logic             clamp_q, clamp_d;

    logic [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic             accept;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    cosine_series_mult u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SQR;
            S_SQR:   state_d = S_MULX;
            S_MULX:  state_d = S_MULC;
            S_MULC:  state_d = S_ACC;
            S_ACC:   state_d = (k_q < K_LAST) ? S_MULX : S_DONE;
            S_DONE:  state_d = start ? S_SQR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_a = t_q;
        mul_b = x2_q;
        unique case (state_q)
            S_SQR: begin
                mul_a = x_q;
                mul_b = x_q;
            end
            S_MULC: begin
                mul_a = p_q;
                mul_b = coef(k_q);
            end
            default: begin
                mul_a = t_q;
                mul_b = x2_q;
            end
        endcase
    end

    always_comb begin
        x_d     = x_q;
        x2_d    = x2_q;
        p_d     = p_q;
        t_d     = t_q;
        acc_d   = acc_q;
        res_d   = res_q;
        k_d     = k_q;
        clamp_d = clamp_q;
        if (accept) begin
            clamp_d = (x > XMAXV);
            x_d     = (x > XMAXV) ? XMAXV : x;
            t_d     = ONEV;
            acc_d   = $signed(ONEV);
            k_d     = 3'd1;
        end
        unique case (state_q)
            S_SQR:  x2_d = mul_p;
            S_MULX: p_d  = mul_p;
            S_MULC: t_d  = mul_p;
            S_ACC: begin
                // odd terms carry the minus sign of the series
                if (k_q[0]) acc_d = acc_q - $signed(t_q);
                else        acc_d = acc_q + $signed(t_q);
                if (k_q < K_LAST) k_d = k_q + 3'd1;
                else              res_d = acc_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            x2_q    <= '0;
            p_q     <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            k_q     <= '0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
            p_q     <= p_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            k_q     <= k_d;
            clamp_q <= clamp_d;
        end
    end

    assign busy      = (state_q == S_SQR)  || (state_q == S_MULX) ||
                       (state_q == S_MULC) || (state_q == S_ACC);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign range_err = done && clamp_q;

endmodule

// File: tb/tb_cosine_series.sv
// Directed and randomized checks of cosine_series against an arithmetic model
// of the truncated Taylor recurrence, for 4-term and 2-term builds.
module tb_cosine_series;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;

    logic        busy4, done4, rerr4;
    logic [15:0] res4;
    logic        busy2, done2, rerr2;
    logic [15:0] res2;

    int n_cmp = 0;
    int n_err = 0;

    int coefs [4] = '{1024, 171, 68, 37};

    always #5 clk = ~clk;

    cosine_series dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .busy      (busy4),
        .done      (done4),
        .result    (res4),
        .range_err (rerr4)
    );

    cosine_series #(.N_TERMS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x         (x),
        .busy      (busy2),
        .done      (done2),
        .result    (res2),
        .range_err (rerr2)
    );

    // Truncated Q5.11 Taylor recurrence computed with wide integers.
    function automatic logic [15:0] ref_cos(input int xin, input int n);
        longint xc, x2, t, acc;
        logic [15:0] r;
        xc  = (xin > 6434) ? 6434 : xin;
        x2  = ((xc * xc) / 2048) % 65536;
        t   = 2048;
        acc = 2048;
        for (int k = 1; k <= n; k++) begin
            t = ((t * x2) / 2048) % 65536;
            t = ((t * coefs[k-1]) / 2048) % 65536;
            acc = (k % 2 == 1) ? acc - t : acc + t;
        end
        r = acc[15:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_one(input logic [15:0] xv);
        int lat4, lat2, c;
        logic busy_c1;
        lat4 = 0;
        lat2 = 0;
        busy_c1 = 1'b0;
        x = xv;
        start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        while (c <= 40 && lat4 == 0) begin
            if (c == 1) busy_c1 = busy4;
            if (done2 && lat2 == 0) lat2 = c;
            if (done4) lat4 = c;
            else step();
            c++;
        end
        check("busy_after_start", 32'(busy_c1), 32'd1);
        check("latency_n4", lat4, 14);
        check("latency_n2", lat2, 8);
        check("busy_in_done", 32'(busy4), 32'd0);
        check("result_n4", 32'(res4), 32'(ref_cos(int'(xv), 4)));
        check("range_err", 32'(rerr4), 32'(xv > 16'd6434));
        check("result_n2", 32'(res2), 32'(ref_cos(int'(xv), 2)));
        step();
        check("done_pulse_width", 32'(done4), 32'd0);
    endtask

    initial begin
        int ndone, gap, last_gap_ok;
        logic [15:0] saved, xa, xn;

        rst = 1'b1;
        start = 1'b1;
        x = 16'd100;
        repeat (3) step();
        start = 1'b0;
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_result", 32'(res4), 32'd0);
        check("rst_range_err", 32'(rerr4), 32'd0);
        rst = 1'b0;
        step();

        run_one(16'd0);
        check("cos0_const", 32'(res4), 32'd2048);

        run_one(16'd2048);
        check("cos1_n4_const", 32'(res4), 32'd1107);
        check("cos1_n2_const", 32'(res2), 32'd1109);

        run_one(16'd7000);
        check("clamp_same_as_xmax", 32'(res4), 32'(ref_cos(6434, 4)));
        run_one(16'd6434);
        run_one(16'd6435);

        for (int i = 0; i < 8; i++) run_one(16'($urandom_range(0, 8000)));

        // start re-pulsed and x disturbed while busy
        xa = 16'd4000;
        x = xa;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        saved = '0;
        for (int c = 1; c <= 30; c++) begin
            if (done4) begin
                ndone++;
                saved = res4;
            end
            start = (c == 3 || c == 6 || c == 9);
            if (start) x = 16'($urandom_range(0, 8000));
            step();
        end
        start = 1'b0;
        check("repulse_done_count", ndone, 1);
        check("repulse_result", 32'(saved), 32'(ref_cos(int'(xa), 4)));

        // reset mid-run aborts the computation
        x = 16'd1500;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_result", 32'(res4), 32'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done4) ndone++;
            step();
        end
        check("abort_no_done", ndone, 0);
        check("abort_result_held", 32'(res4), 32'd0);
        run_one(16'd1500);

        // start held high: back-to-back runs, new x captured at each DONE
        xa = 16'($urandom_range(0, 6434));
        x = xa;
        start = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            gap = 0;
            while (!done4 && gap < 40) begin
                step();
                gap++;
            end
            if (r > 0) check("held_gap", gap, 3 * 4 + 1);
            check("held_result", 32'(res4), 32'(ref_cos(int'(xa), 4)));
            xn = 16'($urandom_range(0, 7000));
            xa = xn;
            x = xn;
            step();
        end
        start = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
